mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Memory/IO responder on the far side of the CPU's byte-wide memory bus. Decodes each cycle's address, returns read data one cycle later and commits writes at the clock edge. Implements byte-addressed RAM plus the memory-mapped UART port (0x30000), cycle counter / program-stop port (0x30004) and the `io_buffer_full` back-pressure flag. Sits between `cpu` and the UART/top-level glue.

## Interface
- `ADDR_W`, 17: RAM address width; RAM holds 2^ADDR_W bytes at 0x0..2^ADDR_W-1.
- `TX_DEPTH`, 8: TX FIFO entries; power of two, >= 4.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when free TX entries <= FULL_MARGIN.

- `clk_in` in 1: the single clock; all state updates on its rising edge.
- `rst_in` in 1: reset, asynchronous, active-high.
- `mem_a` in 32: byte address from CPU; only [17:0] decoded.
- `mem_wr` in 1: 1 = write, 0 = read, every cycle.
- `mem_dout` in 8: write data from CPU.
- `mem_din` out 8: registered read data to CPU.
- `io_buffer_full` out 1: TX FIFO near-full back-pressure to CPU.
- `tx_data` out 8: head byte of TX FIFO.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: UART transmitter accepts head byte.
- `rx_data` in 8: received byte from UART.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: RX holding register empty.
- `program_stop` out 1: sticky, set by write to 0x30004.

## Operation
- Decode: `mem_a[17:16]==2'b11` -> IO space; else RAM if `mem_a[17:0] < 2^ADDR_W`; else unmapped.
- RAM read: byte at address N on cycle t appears on `mem_din` in cycle t+1. RAM write: `mem_dout` stored at edge. RAM contents not reset.
- Unmapped: reads return 0x00, writes ignored.
- IO by `mem_a[2:0]`:
  - 0 read: return RX holding byte and clear it; if empty return 0x00.
  - 0 write: push `mem_dout` to TX FIFO; 0x00 ignored.
  - 4 read: latch 32-bit cycle counter into snapshot, return snapshot[7:0]; 5/6/7 read return snapshot[15:8]/[23:16]/[31:24] (no relatch).
  - 4 write: set `program_stop`; push 0x00 to TX FIFO.
  - Other offsets: read 0x00, write ignored.
- Cycle counter: 32-bit, +1 every clock after reset, wraps 0xFFFFFFFF->0, freezes once `program_stop`=1.
- TX FIFO: `tx_valid`=!empty, `tx_data`=head; pop on `tx_valid && tx_ready`. Push when full is dropped. Simultaneous push+pop when full: pop and push both occur, count unchanged. `io_buffer_full` = (count >= TX_DEPTH-FULL_MARGIN), registered from post-update count.
- RX: `rx_ready`=!held. Capture on `rx_valid && rx_ready`. Read of 0x30000 in same cycle as capture into empty register returns 0x00 and new byte is kept.

## Timing
- Reset (async, immediate): `mem_din`=0x00, `tx_valid`=0, `io_buffer_full`=0, `rx_ready`=1, `program_stop`=0, counter=0, snapshot=0, FIFO pointers=0. Reset mid-transfer discards FIFO and RX contents; RAM retained.
- Read latency exactly 1 cycle, all spaces; `mem_din` holds last read value during write cycles.
- Write latency 0 wait cycles: back-to-back writes every cycle accepted.
- Read-after-write same RAM address on consecutive cycles returns new value.
- FIFO push at t makes `tx_valid`=1 at t+1; pop at t updates `tx_data` at t+1.
- Counter snapshot taken at edge ending the 0x30004 read cycle; value read is counter value in that cycle.

## Configuration
- `MEM_IO_ERR_EN` defined: adds output `bus_err` (1 bit, reset 0), sticky set on any unmapped access, write to full TX FIFO, or IO write to offsets other than 0/4; cleared only by reset.
- Not defined: port absent; those events silently ignored as above.

## Test plan
- Write 0xA5 to 0x00010, read 0x00010 next cycle -> `mem_din`=0xA5 exactly one cycle after read.
- Hold `tx_ready`=0, write 0x41 ×6 to 0x30000 (TX_DEPTH=8, FULL_MARGIN=2) -> `io_buffer_full`=1 after 6th push; 0x00 write -> no push.
- Fill FIFO with 9 pushes, `tx_ready`=0 -> 8 entries, 9th dropped (`bus_err`=1 with MEM_IO_ERR_EN); drain -> bytes in order.
- `rx_valid` with 0x5A, read 0x30000 -> 0x5A, immediate second read -> 0x00, `rx_ready` back to 1.
- Read 0x30004..0x30007 after 1000 cycles of reset release -> bytes assemble to snapshot consistent across all four reads.
- Write 0x30004 -> `program_stop`=1, 0x00 emitted on `tx_data`, counter frozen; assert `rst_in` mid-stream -> all outputs to reset values immediately.

Source files
------------

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus UART TX/RX, cycle counter and program-stop IO on the CPU bus.
// Defining MEM_IO_ERR_EN adds a sticky bus_err output.
module mem_io_responder #(
  parameter int ADDR_W      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
`ifdef MEM_IO_ERR_EN
  output logic        bus_err,
`endif
  output logic        program_stop
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [18:0] RAM_END = 19'(2 ** ADDR_W);
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0] ram [2**ADDR_W];
  logic [7:0] fifo [TX_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nx;
  logic [31:0] cycles, snap;
  logic [7:0] rx_byte, rd_val, push_data;
  logic rx_held;
  logic is_io, is_ram;
  logic [2:0] off;
  logic io_rd0, io_rd4, io_wr0, io_wr4;
  logic push_req, do_push, pop, full;
  logic unused_a;

  assign unused_a = ^mem_a[31:18];
  assign off = mem_a[2:0];
  assign is_io = mem_a[17:16] == 2'b11;
  assign is_ram = !is_io && ({1'b0, mem_a[17:0]} < RAM_END);

  assign io_rd0 = is_io && !mem_wr && off == 3'd0;
  assign io_rd4 = is_io && !mem_wr && off == 3'd4;
  assign io_wr0 = is_io && mem_wr && off == 3'd0;
  assign io_wr4 = is_io && mem_wr && off == 3'd4;

  assign tx_valid = count != '0;
  assign tx_data = fifo[rd_ptr];
  assign rx_ready = !rx_held;
  assign full = count == DEPTH_C;

  // A stop write emits a 0x00 marker; a literal 0x00 data write is not queued.
  assign push_req = (io_wr0 && mem_dout != 8'h00) || io_wr4;
  assign push_data = io_wr4 ? 8'h00 : mem_dout;
  assign pop = tx_valid && tx_ready;
  assign do_push = push_req && (!full || pop);
  assign count_nx = count + CW'(do_push) - CW'(pop);

  always_comb begin
    rd_val = 8'h00;
    unique case (1'b1)
      is_ram: rd_val = ram[mem_a[ADDR_W-1:0]];
      is_io: begin
        unique case (off)
          3'd0: rd_val = rx_held ? rx_byte : 8'h00;
          3'd4: rd_val = cycles[7:0];
          3'd5: rd_val = snap[15:8];
          3'd6: rd_val = snap[23:16];
          3'd7: rd_val = snap[31:24];
          default: rd_val = 8'h00;
        endcase
      end
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (is_ram && mem_wr)
      ram[mem_a[ADDR_W-1:0]] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (do_push)
      fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din <= 8'h00;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      io_buffer_full <= 1'b0;
      cycles <= 32'd0;
      snap <= 32'd0;
      program_stop <= 1'b0;
      rx_held <= 1'b0;
      rx_byte <= 8'h00;
    end else begin
      if (!mem_wr)
        mem_din <= rd_val;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      count <= count_nx;
      io_buffer_full <= count_nx >= FULL_LVL;
      if (!program_stop)
        cycles <= cycles + 32'd1;
      if (io_rd4)
        snap <= cycles;
      if (io_wr4)
        program_stop <= 1'b1;
      // A read that races a capture into an empty holder sees 0x00.
      if (io_rd0 && rx_held)
        rx_held <= 1'b0;
      if (rx_valid && !rx_held) begin
        rx_held <= 1'b1;
        rx_byte <= rx_data;
      end
    end
  end

`ifdef MEM_IO_ERR_EN
  logic err_ev;
  assign err_ev = (!is_io && !is_ram)
               || (push_req && full && !pop)
               || (is_io && mem_wr && off != 3'd0 && off != 3'd4);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      bus_err <= 1'b0;
    else if (err_ev)
      bus_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed steps plus random traffic
// against a queue/array reference model.
module tb_mem_io_responder;
  localparam int DEPTH = 8;
  localparam int MARGIN = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a = 32'd0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = 8'h00;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_stop;
`ifdef MEM_IO_ERR_EN
  logic        bus_err;
`endif

  mem_io_responder #(
    .ADDR_W(17),
    .TX_DEPTH(DEPTH),
    .FULL_MARGIN(MARGIN)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .mem_a(mem_a),
    .mem_wr(mem_wr),
    .mem_dout(mem_dout),
    .mem_din(mem_din),
    .io_buffer_full(io_buffer_full),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
`ifdef MEM_IO_ERR_EN
    .bus_err(bus_err),
`endif
    .program_stop(program_stop)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mram [int];
  logic [7:0]  q [$];
  logic        held;
  logic [7:0]  hbyte;
  logic [7:0]  e_din;
  logic [31:0] cnt;
  logic [31:0] snap;
  logic        stop;
  logic [31:0] pool [16];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held = 1'b0;
    hbyte = 8'h00;
    e_din = 8'h00;
    cnt = 32'd0;
    snap = 32'd0;
    stop = 1'b0;
  endtask

  task automatic check();
    chk("mem_din", 32'(mem_din), 32'(e_din));
    chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    if (q.size() != 0)
      chk("tx_data", 32'(tx_data), 32'(q[0]));
    chk("io_full", 32'(io_buffer_full), 32'(q.size() >= DEPTH - MARGIN));
    chk("rx_ready", 32'(rx_ready), 32'(!held));
    chk("stop", 32'(program_stop), 32'(stop));
  endtask

  // One bus cycle: drive, advance the model across the edge, then compare.
  task automatic step(input logic [31:0] a, input logic wr,
                      input logic [7:0] d, input logic txr,
                      input logic [7:0] rxd, input logic rxv);
    logic [17:0] x;
    logic io, ram, pop, cap, push, ok, stop_old;
    logic [7:0] pd;
    mem_a = a;
    mem_wr = wr;
    mem_dout = d;
    tx_ready = txr;
    rx_data = rxd;
    rx_valid = rxv;
    x = a[17:0];
    io = x[17:16] == 2'b11;
    ram = !io && x < 18'h20000;
    pop = q.size() != 0 && txr;
    ok = q.size() < DEPTH || pop;
    cap = rxv && !held;
    stop_old = stop;
    push = 1'b0;
    pd = 8'h00;
    if (!wr) begin
      if (ram) e_din = mram[int'(x)];
      else if (io) begin
        case (a[2:0])
          3'd0: begin
            e_din = held ? hbyte : 8'h00;
            held = 1'b0;
          end
          3'd4: begin
            e_din = cnt[7:0];
            snap = cnt;
          end
          3'd5: e_din = snap[15:8];
          3'd6: e_din = snap[23:16];
          3'd7: e_din = snap[31:24];
          default: e_din = 8'h00;
        endcase
      end else e_din = 8'h00;
    end else begin
      if (ram) mram[int'(x)] = d;
      else if (io && a[2:0] == 3'd0 && d != 8'h00) begin
        push = 1'b1;
        pd = d;
      end else if (io && a[2:0] == 3'd4) begin
        push = 1'b1;
        stop = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    if (push && ok) q.push_back(pd);
    if (cap) begin
      held = 1'b1;
      hbyte = rxd;
    end
    if (!stop_old) cnt = cnt + 32'd1;
    @(negedge clk_in);
    check();
  endtask

  task automatic idle(input logic txr);
    step(pool[1], 1'b0, 8'h00, txr, 8'h00, 1'b0);
  endtask

  initial begin
    logic [31:0] a, hi;
    logic wr;
    logic [2:0] off;
    int r;
    logic [7:0] d;
    logic [7:0] exp_tx [8];
    logic [31:0] asm;

    model_reset();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check();

    pool[0] = 32'h10;
    for (int i = 1; i < 16; i++)
      pool[i] = 32'($urandom_range(0, 32'h1FFFF));
    for (int i = 0; i < 16; i++) begin
      hi = 32'($urandom()) & 32'hFFFC_0000;
      step(hi | pool[i], 1'b1, 8'($urandom_range(1, 255)), 1'b0, 8'h00, 1'b0);
    end

    step(32'h10, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    step(32'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("ram_a5", 32'(mem_din), 32'hA5);

    for (int i = 0; i < 6; i++)
      step(32'h30000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    chk("full_after6", 32'(io_buffer_full), 32'd1);
    step(32'h30000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step(32'h30000, 1'b1, 8'h51, 1'b0, 8'h00, 1'b0);
    step(32'h30000, 1'b1, 8'h52, 1'b0, 8'h00, 1'b0);
    step(32'h30000, 1'b1, 8'h53, 1'b0, 8'h00, 1'b0);
    exp_tx = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h51, 8'h52};
    for (int i = 0; i < 8; i++) begin
      chk("drain", 32'(tx_data), 32'(exp_tx[i]));
      idle(1'b1);
    end
    chk("drained", 32'(tx_valid), 32'd0);

    step(pool[2], 1'b0, 8'h00, 1'b0, 8'h5A, 1'b1);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rx_5a", 32'(mem_din), 32'h5A);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rx_empty", 32'(mem_din), 32'h00);
    chk("rx_ready_back", 32'(rx_ready), 32'd1);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 8'h77, 1'b1);
    chk("rx_race", 32'(mem_din), 32'h00);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rx_kept", 32'(mem_din), 32'h77);

    step(32'h20010, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
    step(32'h20010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("unmapped", 32'(mem_din), 32'h00);

    repeat (1000) idle(1'b1);
    asm = 32'd0;
    for (int i = 0; i < 4; i++) begin
      step(32'h30004 + 32'(i), 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      asm = asm | (32'(mem_din) << (8 * i));
    end
    chk("snap_asm", asm, snap);

    for (int n = 0; n < 400; n++) begin
      hi = 32'($urandom()) & 32'hFFFC_0000;
      r = int'($urandom_range(0, 9));
      wr = 1'($urandom_range(0, 1));
      off = 3'($urandom_range(0, 7));
      if (r < 5) a = hi | pool[$urandom_range(0, 15)];
      else if (r < 8) begin
        if (wr && off == 3'd4) off = 3'd0;
        a = hi | 32'h30000 | (32'($urandom_range(0, 8191)) << 3) | 32'(off);
      end else if (r == 8) begin
        wr = 1'b0;
        a = hi | 32'h30000;
      end else a = hi | 32'h20000 | 32'($urandom_range(0, 16'hFFFF));
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      step(a, wr, d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end

    repeat (10) idle(1'b1);
    step(32'h30004, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    chk("stop_set", 32'(program_stop), 32'd1);
    chk("stop_marker", 32'(tx_data), 32'h00);
    chk("stop_valid", 32'(tx_valid), 32'd1);
    repeat (20) idle(1'b0);
    step(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (5) idle(1'b0);
    step(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    step(32'h30000, 1'b1, 8'h61, 1'b0, 8'hC3, 1'b1);
    idle(1'b0);
    #2 rst_in = 1'b1;
    #1;
    chk("rst_din", 32'(mem_din), 32'h00);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_full", 32'(io_buffer_full), 32'd0);
    chk("rst_rxr", 32'(rx_ready), 32'd1);
    chk("rst_stop", 32'(program_stop), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    check();
    repeat (5) idle(1'b0);
    step(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("cnt_restart", 32'(mem_din), 32'd5);
    step(pool[0], 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
